// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit : program counter with built-in circular return-address stack (RAS)
//
// Each cycle the next PC is chosen from one of four sources:
//   00 sequential step, 01 relative branch, 10 absolute jump, 11 return (pop).
// The PC and the RAS update only when C_PCWrite is high. C_Call pushes
// PC_OUT+STEP. When a return and a call happen together, the top entry is
// replaced. When the RAS is full it wraps and overwrites its oldest entry.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   C_PCWrite    update enable (0 = stall)
//   C_PCSrc      next-PC select
//   C_Call       push return address this update
//   BR_OFF       signed branch offset (OFF_W bits)
//   JMP_ADDR     absolute jump target
//   PC_OUT       registered current PC
//   PC_NEXT      combinational next-PC candidate
//   RAS_CNT      number of valid RAS entries
//   RAS_OVF      sticky: push while full
//   RAS_UNF      sticky: pop while empty
//   PC_MISALIGN  (PC_ALIGN_TRAP_EN only) sticky misaligned-target trap
//
// Optional feature macro: PC_ALIGN_TRAP_EN. When it is defined, an update
// whose target is not a multiple of STEP is suppressed and PC_MISALIGN is set.
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int PC_W         = 16,
  parameter int OFF_W        = 8,
  parameter int STEP         = 1,
  parameter int RESET_VECTOR = 0,
  parameter int RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         C_PCWrite,
  input  logic [1:0]                   C_PCSrc,
  input  logic                         C_Call,
  input  logic [OFF_W-1:0]             BR_OFF,
  input  logic [PC_W-1:0]              JMP_ADDR,
  output logic [PC_W-1:0]              PC_OUT,
  output logic [PC_W-1:0]              PC_NEXT,
  output logic [$clog2(RAS_DEPTH):0]   RAS_CNT,
  output logic                         RAS_OVF,
  output logic                         RAS_UNF
`ifdef PC_ALIGN_TRAP_EN
  ,
  output logic                         PC_MISALIGN
`endif
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0]  STEP_V = PC_W'(STEP);
  localparam logic [PC_W-1:0]  RST_V  = PC_W'(RESET_VECTOR);
  localparam logic [CNT_W-1:0] FULL_V = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    SRC_SEQ = 2'b00,
    SRC_BR  = 2'b01,
    SRC_JMP = 2'b10,
    SRC_RET = 2'b11
  } src_t;

  // Saturating increment: the count sticks at the depth while the pointer wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == FULL_V) ? c : c + CNT_W'(1);
  endfunction

  logic [PC_W-1:0]          ras [RAS_DEPTH];
  logic [PTR_W-1:0]         tos;
  logic [PTR_W-1:0]         tos_n;
  logic [CNT_W-1:0]         cnt_n;
  logic                     ovf_n;
  logic                     unf_n;
  logic                     wr_en;
  logic [PTR_W-1:0]         wr_idx;
  logic [PC_W-1:0]          ret_addr;
  logic [PC_W-1:0]          top;
  logic signed [OFF_W-1:0]  off_s;
  logic signed [PC_W-1:0]   off_ext;
  logic                     empty;
  logic                     full;
  logic                     is_ret;
  logic                     upd;
  src_t                     src;

  assign src      = src_t'(C_PCSrc);
  assign is_ret   = (src == SRC_RET);
  assign empty    = (RAS_CNT == '0);
  assign full     = (RAS_CNT == FULL_V);
  assign ret_addr = PC_OUT + STEP_V;
  assign top      = ras[tos];
  assign off_s    = BR_OFF;
  assign off_ext  = PC_W'(off_s);

  always_comb begin
    PC_NEXT = ret_addr;
    case (src)
      SRC_SEQ: PC_NEXT = ret_addr;
      SRC_BR:  PC_NEXT = PC_OUT + off_ext;
      SRC_JMP: PC_NEXT = JMP_ADDR;
      SRC_RET: PC_NEXT = empty ? RST_V : top;
      default: PC_NEXT = ret_addr;
    endcase
  end

`ifdef PC_ALIGN_TRAP_EN
  logic misalign;
  assign misalign = (PC_NEXT % STEP_V) != '0;
  // A misaligned target blocks the whole update, RAS included.
  assign upd = C_PCWrite && !misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_MISALIGN <= 1'b0;
    end else if (C_PCWrite && misalign) begin
      PC_MISALIGN <= 1'b1;
    end
  end
`else
  assign upd = C_PCWrite;
`endif

  // RAS next-state: tos always indexes the newest entry.
  always_comb begin
    tos_n  = tos;
    cnt_n  = RAS_CNT;
    ovf_n  = RAS_OVF;
    unf_n  = RAS_UNF;
    wr_en  = 1'b0;
    wr_idx = tos;
    if (upd) begin
      if (is_ret) begin
        if (empty) unf_n = 1'b1;
        if (C_Call) begin
          // Pop and push together: overwrite the top in place.
          wr_en  = 1'b1;
          wr_idx = tos;
          if (empty) cnt_n = CNT_W'(1);
        end else if (!empty) begin
          tos_n = tos - PTR_W'(1);
          cnt_n = RAS_CNT - CNT_W'(1);
        end
      end else if (C_Call) begin
        // When full, tos+1 is the oldest slot, so wrapping overwrites it.
        wr_en  = 1'b1;
        wr_idx = tos + PTR_W'(1);
        tos_n  = tos + PTR_W'(1);
        cnt_n  = sat_inc(RAS_CNT);
        if (full) ovf_n = 1'b1;
      end
    end
  end

  // Stage boundary: control state (PC, pointer, count, flags) under reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_OUT  <= RST_V;
      tos     <= '0;
      RAS_CNT <= '0;
      RAS_OVF <= 1'b0;
      RAS_UNF <= 1'b0;
    end else begin
      tos     <= tos_n;
      RAS_CNT <= cnt_n;
      RAS_OVF <= ovf_n;
      RAS_UNF <= unf_n;
      if (upd) PC_OUT <= PC_NEXT;
    end
  end

  // Stage boundary: RAS storage, data only, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) ras[wr_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit : randomized and directed bench for pc_unit.
// A queue-based return-stack model predicts each cycle's PC_NEXT and the
// post-edge state. The driver pushes each prediction to a scoreboard, and a
// separate monitor pops and compares it after every rising edge.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  localparam int DEPTH  = 4;
  localparam int STEP_T = 1;
  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        C_PCWrite = 1'b0;
  logic [1:0]  C_PCSrc = 2'b00;
  logic        C_Call = 1'b0;
  logic [7:0]  BR_OFF = 8'h00;
  logic [15:0] JMP_ADDR = 16'h0000;
  logic [15:0] PC_OUT;
  logic [15:0] PC_NEXT;
  logic [2:0]  RAS_CNT;
  logic        RAS_OVF;
  logic        RAS_UNF;
`ifdef PC_ALIGN_TRAP_EN
  logic        PC_MISALIGN;
  logic        al_wr = 1'b0;
  logic [1:0]  al_src = 2'b00;
  logic [15:0] al_jmp = 16'h0000;
  logic [15:0] al_pc;
  logic [15:0] al_next;
  logic [2:0]  al_cnt;
  logic        al_ovf;
  logic        al_unf;
  logic        al_mis;
`endif

  always #5 clk = ~clk;

  pc_unit #(.PC_W(16), .OFF_W(8), .STEP(STEP_T), .RESET_VECTOR(0), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .C_PCWrite(C_PCWrite), .C_PCSrc(C_PCSrc), .C_Call(C_Call),
    .BR_OFF(BR_OFF), .JMP_ADDR(JMP_ADDR), .PC_OUT(PC_OUT), .PC_NEXT(PC_NEXT),
    .RAS_CNT(RAS_CNT), .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF)
`ifdef PC_ALIGN_TRAP_EN
    , .PC_MISALIGN(PC_MISALIGN)
`endif
  );

`ifdef PC_ALIGN_TRAP_EN
  pc_unit #(.PC_W(16), .OFF_W(8), .STEP(2), .RESET_VECTOR(0), .RAS_DEPTH(DEPTH)) u_al (
    .clk(clk), .rst(rst), .C_PCWrite(al_wr), .C_PCSrc(al_src), .C_Call(1'b0),
    .BR_OFF(8'h00), .JMP_ADDR(al_jmp), .PC_OUT(al_pc), .PC_NEXT(al_next),
    .RAS_CNT(al_cnt), .RAS_OVF(al_ovf), .RAS_UNF(al_unf), .PC_MISALIGN(al_mis)
  );
`endif

  typedef struct {
    logic [15:0] nxt;
    logic [15:0] pc;
    int          cnt;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;

  // Reference model: stack as a queue, newest at the back.
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  bit          m_ovf;
  bit          m_unf;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic m_reset();
    m_pc = RV;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the result, then wait for the next negedge.
  task automatic drive(input bit wr, input logic [1:0] src, input bit call,
                       input logic [7:0] off, input logic [15:0] jmp);
    exp_t        e;
    logic [15:0] ret;
    logic [15:0] nxt;
    logic [15:0] dummy;
    C_PCWrite = wr;
    C_PCSrc   = src;
    C_Call    = call;
    BR_OFF    = off;
    JMP_ADDR  = jmp;
    ret = m_pc + 16'(STEP_T);
    case (src)
      2'd0:    nxt = ret;
      2'd1:    nxt = m_pc + {{8{off[7]}}, off};
      2'd2:    nxt = jmp;
      default: nxt = (m_ras.size() > 0) ? m_ras[$] : RV;
    endcase
    if (wr) begin
      if (src == 2'd3) begin
        if (m_ras.size() == 0) m_unf = 1'b1;
        else dummy = m_ras.pop_back();
        if (call) m_ras.push_back(ret);
      end else if (call) begin
        m_ras.push_back(ret);
        if (m_ras.size() > DEPTH) begin
          dummy = m_ras.pop_front();
          m_ovf = 1'b1;
        end
      end
      m_pc = nxt;
    end
    e.nxt = nxt;
    e.pc  = m_pc;
    e.cnt = m_ras.size();
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, away from any edge, with the scoreboard drained.
  task automatic mid_reset();
    C_PCWrite = 1'b0;
    C_Call    = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("async_rst_pc", PC_OUT, RV);
    chk("async_rst_cnt", RAS_CNT, 0);
    chk("async_rst_flags", {RAS_OVF, RAS_UNF}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: sample PC_NEXT just before the edge and the state just after it.
  initial begin
    logic [15:0] next_cap;
    exp_t        e;
    forever begin
      @(negedge clk);
      #4 next_cap = PC_NEXT;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_pc_next", next_cap, e.nxt);
        chk("sb_pc_out", PC_OUT, e.pc);
        chk("sb_ras_cnt", RAS_CNT, e.cnt);
        chk("sb_ras_ovf", RAS_OVF, e.ovf);
        chk("sb_ras_unf", RAS_UNF, e.unf);
      end
    end
  end

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_pc", PC_OUT, RV);
    chk("reset_cnt", RAS_CNT, 0);
    chk("reset_flags", {RAS_OVF, RAS_UNF}, 0);
    rst = 1'b0;

    // Reset from a non-zero PC, then step.
    drive(1, 2'd2, 0, 8'h00, 16'h0025);
    chk("pre_rst_pc", PC_OUT, 16'h0025);
    mid_reset();
    drive(1, 2'd0, 0, 8'h00, 16'h0000);
    chk("step1", PC_OUT, 16'h0001);
    drive(1, 2'd0, 0, 8'h00, 16'h0000);
    chk("step2", PC_OUT, 16'h0002);
    drive(1, 2'd0, 0, 8'h00, 16'h0000);
    chk("step3", PC_OUT, 16'h0003);

    // Stall, negative branch, wrap-around.
    drive(1, 2'd2, 0, 8'h00, 16'h0010);
    drive(0, 2'd2, 1, 8'h00, 16'h1234);
    chk("stall_pc", PC_OUT, 16'h0010);
    chk("stall_cnt", RAS_CNT, 0);
    drive(1, 2'd1, 0, 8'hFC, 16'h0000);
    chk("branch_neg", PC_OUT, 16'h000C);
    drive(1, 2'd2, 0, 8'h00, 16'hFFFF);
    drive(1, 2'd0, 0, 8'h00, 16'h0000);
    chk("wrap", PC_OUT, 16'h0000);

    // Call and return.
    drive(1, 2'd2, 0, 8'h00, 16'h0100);
    drive(1, 2'd2, 1, 8'h00, 16'h0200);
    chk("call_pc", PC_OUT, 16'h0200);
    chk("call_cnt", RAS_CNT, 1);
    drive(1, 2'd0, 0, 8'h00, 16'h0000);
    drive(1, 2'd3, 0, 8'h00, 16'h0000);
    chk("ret_pc", PC_OUT, 16'h0101);
    chk("ret_cnt", RAS_CNT, 0);

    // Overflow: five calls from 0x10..0x50, then five returns.
    drive(1, 2'd2, 0, 8'h00, 16'h0010);
    for (int i = 1; i <= 5; i++) drive(1, 2'd2, 1, 8'h00, 16'((i + 1) * 16));
    chk("ovf_flag", RAS_OVF, 1);
    chk("ovf_cnt", RAS_CNT, 4);
    for (int i = 5; i >= 2; i--) begin
      drive(1, 2'd3, 0, 8'h00, 16'h0000);
      chk("ovf_ret_pc", PC_OUT, i * 16 + 1);
    end
    drive(1, 2'd3, 0, 8'h00, 16'h0000);
    chk("unf_pc", PC_OUT, RV);
    chk("unf_flag", RAS_UNF, 1);
    chk("unf_cnt", RAS_CNT, 0);

    // Simultaneous pop and push.
    mid_reset();
    drive(1, 2'd2, 0, 8'h00, 16'h0050);
    drive(1, 2'd2, 1, 8'h00, 16'h0080);
    drive(1, 2'd2, 1, 8'h00, 16'h0300);
    drive(1, 2'd3, 1, 8'h00, 16'h0000);
    chk("swap_pc", PC_OUT, 16'h0081);
    chk("swap_cnt", RAS_CNT, 2);
    drive(1, 2'd3, 0, 8'h00, 16'h0000);
    chk("swap_new_top", PC_OUT, 16'h0301);
    drive(1, 2'd3, 0, 8'h00, 16'h0000);
    chk("swap_old_entry", PC_OUT, 16'h0051);
    drive(1, 2'd2, 0, 8'h00, 16'h0300);
    drive(1, 2'd3, 1, 8'h00, 16'h0000);
    chk("swap_empty_pc", PC_OUT, RV);
    chk("swap_empty_unf", RAS_UNF, 1);
    chk("swap_empty_cnt", RAS_CNT, 1);
    drive(1, 2'd3, 0, 8'h00, 16'h0000);
    chk("swap_empty_ret", PC_OUT, 16'h0301);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) mid_reset();
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
            8'($urandom), 16'($urandom));
    end

`ifdef PC_ALIGN_TRAP_EN
    chk("no_misalign_step1", PC_MISALIGN, 0);
    al_wr = 1'b1; al_src = 2'd2; al_jmp = 16'h0103;
    @(negedge clk);
    chk("misalign_set", al_mis, 1);
    chk("misalign_hold_pc", al_pc, 16'h0000);
    al_jmp = 16'h0104;
    @(negedge clk);
    chk("misalign_sticky", al_mis, 1);
    chk("aligned_jump_pc", al_pc, 16'h0104);
    al_wr = 1'b0;
`endif

    C_PCWrite = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
